// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int LU_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_fwd.sv
// Per-operand forwarding select: youngest producer wins, x0 never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))
            fwd = FWD_EXMEM;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: forwarding, load-use stall, memory-wait freeze
// with timeout, branch flush and saturating perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              front_stall,
    output logic              idex_bubble,
    output logic              freeze,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_e         state_q, state_d;
    logic [LU_W-1:0]   lu_q, lu_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_set;
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              lu_hit, mem_stall, wait_live;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_a_raw)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_b_raw)
    );

    assign lu_hit = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;
    assign wait_live = !mem_ready && (wait_q < WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            lu_q        <= '0;
            wait_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            lu_q    <= lu_d;
            wait_q  <= wait_d;
            if (timeout_set)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        lu_d        = lu_q;
        wait_d      = wait_q;
        timeout_set = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else if (!ex_branch_taken && lu_hit && (LOAD_LAT > 1)) begin
                    state_d = ST_LU_STALL;
                    lu_d    = LU_W'(LOAD_LAT - 1);
                end
            end
            ST_LU_STALL: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else if (ex_branch_taken) begin
                    state_d = ST_RUN;
                    lu_d    = '0;
                end else begin
                    lu_d = lu_q - LU_W'(1);
                    if (lu_q == LU_W'(1))
                        state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_live) begin
                    wait_d = wait_q + WAIT_W'(1);
                end else begin
                    timeout_set = !mem_ready;
                    // A flush on the way out squashes the stalled consumer
                    if (ex_branch_taken) begin
                        state_d = ST_RUN;
                        lu_d    = '0;
                    end else begin
                        state_d = (lu_q != '0) ? ST_LU_STALL : ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        front_stall = 1'b0;
        idex_bubble = 1'b0;
        freeze      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (!rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            unique case (state_q)
                ST_RUN:      freeze = mem_stall;
                ST_LU_STALL: freeze = mem_stall;
                ST_MEM_WAIT: freeze = wait_live;
                default:     freeze = 1'b0;
            endcase
            if (!freeze && ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (!freeze && state_q != ST_MEM_WAIT) begin
                front_stall = (state_q == ST_LU_STALL) || lu_hit;
                idex_bubble = front_stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze || front_stall) && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (ifid_flush && !(&flush_count))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding table plus stall,
// freeze, timeout, flush, reset and counter-saturation sequences.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load;
    logic       ex_branch_taken, mem_reg_write, mem_req, mem_ready;
    logic       wb_reg_write;

    logic [1:0]  a0, b0, a1, b1;
    logic        fs0, bub0, frz0, iff0, ief0, to0;
    logic        fs1, bub1, frz1, iff1, ief1, to1;
    logic [31:0] st0, fc0;
    logic [3:0]  st1, fc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW(5), .LOAD_LAT(2), .MAX_WAIT(4), .CNT_W(32)
    ) u0 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fwd_a(a0), .fwd_b(b0),
        .front_stall(fs0), .idex_bubble(bub0), .freeze(frz0),
        .ifid_flush(iff0), .idex_flush(ief0), .mem_timeout(to0),
        .stall_cycles(st0), .flush_count(fc0)
    );

    hazard_ctrl_unit #(
        .REG_AW(5), .LOAD_LAT(1), .MAX_WAIT(16), .CNT_W(4)
    ) u1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fwd_a(a1), .fwd_b(b1),
        .front_stall(fs1), .idex_bubble(bub1), .freeze(frz1),
        .ifid_flush(iff1), .idex_flush(ief1), .mem_timeout(to1),
        .stall_cycles(st1), .flush_count(fc1)
    );

    typedef struct {
        logic [4:0] mem_rd;
        logic       mem_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] ea;
        logic [1:0] eb;
    } fv_t;

    fv_t fv [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_reg_write = 0; ex_is_load = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_reg_write = 0; mem_req = 0; mem_ready = 0;
        wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic do_reset;
        clr_in;
        rst = 1;
        nxt;
        nxt;
        rst = 0;
    endtask

    task automatic load_hit;
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs2 = 5; id_use_rs2 = 1;
    endtask

    initial begin
        int n;
        fv[0] = '{3, 1, 3, 1, 3, 0, 2'b10, 2'b00};
        fv[1] = '{3, 0, 3, 1, 3, 0, 2'b01, 2'b00};
        fv[2] = '{0, 1, 0, 1, 0, 0, 2'b00, 2'b00};
        fv[3] = '{7, 1, 9, 1, 9, 7, 2'b01, 2'b10};
        fv[4] = '{4, 1, 4, 1, 5, 6, 2'b00, 2'b00};
        fv[5] = '{12, 1, 12, 0, 1, 12, 2'b00, 2'b10};
        fv[6] = '{31, 0, 31, 0, 31, 31, 2'b00, 2'b00};
        fv[7] = '{8, 1, 8, 1, 8, 8, 2'b10, 2'b10};

        // outputs held low during reset even with every hazard present
        clr_in;
        rst = 1;
        nxt;
        load_hit;
        mem_rd = 3; mem_reg_write = 1; ex_rs1 = 3;
        ex_branch_taken = 1; mem_req = 1;
        @(negedge clk);
        chk("rst_fwd_a", a0, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_freeze", frz0, 0);
        chk("rst_flush", iff0, 0);
        nxt;
        clr_in;
        rst = 0;
        @(negedge clk);
        chk("rst_stall_cnt", st0, 0);
        chk("rst_flush_cnt", fc0, 0);
        chk("rst_timeout", to0, 0);
        nxt;

        for (int i = 0; i < 8; i++) begin
            mem_rd = fv[i].mem_rd; mem_reg_write = fv[i].mem_wr;
            wb_rd = fv[i].wb_rd;   wb_reg_write = fv[i].wb_wr;
            ex_rs1 = fv[i].rs1;    ex_rs2 = fv[i].rs2;
            @(negedge clk);
            chk($sformatf("fwd_a[%0d]", i), a0, fv[i].ea);
            chk($sformatf("fwd_b[%0d]", i), b0, fv[i].eb);
            nxt;
        end

        // load-use with LOAD_LAT=2 on u0, LOAD_LAT=1 on u1
        do_reset;
        load_hit;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("lu_bubble0", bub0, 1);
            n += fs0;
            nxt;
            clr_in;
        end
        chk("lu_stall_len", n, 2);
        @(negedge clk);
        chk("lu_stall_cnt", st0, 2);
        chk("lu1_stall_cnt", st1, 1);

        do_reset;
        load_hit;
        id_use_rs2 = 0; id_use_rs1 = 1; id_rs1 = 6;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n += fs0;
            nxt;
        end
        clr_in;
        chk("lu_unused_len", n, 0);
        @(negedge clk);
        chk("lu_unused_cnt", st0, 0);

        // memory wait, ready on the fourth cycle
        do_reset;
        mem_req = 1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n += frz0;
            nxt;
        end
        mem_ready = 1;
        @(negedge clk);
        chk("mw_ready_cycle", frz0, 0);
        nxt;
        clr_in;
        @(negedge clk);
        chk("mw_after", frz0, 0);
        chk("mw_len", n, 3);
        chk("mw_stall_cnt", st0, 3);

        // memory timeout with MAX_WAIT=4
        do_reset;
        mem_req = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n += frz0;
            nxt;
        end
        chk("to_len", n, 4);
        @(negedge clk);
        chk("to_release", frz0, 0);
        chk("to_not_yet", to0, 0);
        nxt;
        mem_req = 0;
        @(negedge clk);
        chk("to_set", to0, 1);
        repeat (3) nxt;
        @(negedge clk);
        chk("to_sticky", to0, 1);
        rst = 1;
        nxt;
        rst = 0;
        @(negedge clk);
        chk("to_cleared", to0, 0);

        // branch beats load-use
        do_reset;
        load_hit;
        ex_branch_taken = 1;
        @(negedge clk);
        chk("br_ifid", iff0, 1);
        chk("br_idex", ief0, 1);
        chk("br_fs", fs0, 0);
        chk("br_bub", bub0, 0);
        nxt;
        clr_in;
        @(negedge clk);
        chk("br_flush_cnt", fc0, 1);
        chk("br_no_lu", fs0, 0);
        chk("br_stall_cnt", st0, 0);

        // branch aborts an LU_STALL
        do_reset;
        load_hit;
        @(negedge clk);
        chk("ab_fs0", fs0, 1);
        nxt;
        clr_in;
        ex_branch_taken = 1;
        @(negedge clk);
        chk("ab_flush", iff0, 1);
        chk("ab_fs1", fs0, 0);
        nxt;
        clr_in;
        @(negedge clk);
        chk("ab_run", fs0, 0);
        chk("ab_stall_cnt", st0, 1);

        // branch held during freeze flushes when freeze drops
        do_reset;
        mem_req = 1;
        ex_branch_taken = 1;
        @(negedge clk);
        chk("bf_frz0", frz0, 1);
        chk("bf_noflush0", iff0, 0);
        nxt;
        @(negedge clk);
        chk("bf_noflush1", iff0, 0);
        nxt;
        mem_ready = 1;
        @(negedge clk);
        chk("bf_frz_drop", frz0, 0);
        chk("bf_flush", iff0, 1);
        nxt;
        clr_in;
        @(negedge clk);
        chk("bf_flush_cnt", fc0, 1);

        // memory wait inside LU_STALL resumes the stall
        do_reset;
        load_hit;
        nxt;
        clr_in;
        mem_req = 1;
        @(negedge clk);
        chk("lm_frz", frz0, 1);
        chk("lm_fs", fs0, 0);
        nxt;
        mem_ready = 1;
        @(negedge clk);
        chk("lm_ready", frz0, 0);
        chk("lm_ready_fs", fs0, 0);
        nxt;
        clr_in;
        @(negedge clk);
        chk("lm_resume", fs0, 1);
        nxt;
        @(negedge clk);
        chk("lm_done", fs0, 0);
        chk("lm_stall_cnt", st0, 3);

        // reset in the middle of LU_STALL and MEM_WAIT
        do_reset;
        load_hit;
        nxt;
        clr_in;
        rst = 1;
        @(negedge clk);
        chk("rl_fs", fs0, 0);
        nxt;
        rst = 0;
        @(negedge clk);
        chk("rl_run", fs0, 0);
        chk("rl_cnt", st0, 0);

        do_reset;
        mem_req = 1;
        nxt;
        nxt;
        rst = 1;
        @(negedge clk);
        chk("rm_frz", frz0, 0);
        nxt;
        rst = 0;
        mem_req = 0;
        @(negedge clk);
        chk("rm_run", frz0, 0);
        chk("rm_cnt", st0, 0);
        chk("rm_to", to0, 0);

        // 4-bit counter saturates after 20 stalled cycles
        do_reset;
        load_hit;
        repeat (20) nxt;
        @(negedge clk);
        chk("sat_fs", fs1, 1);
        chk("sat_cnt", st1, 15);
        clr_in;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
